// File: rtl/demux_1to4_8bit.sv
// 1-to-4 demultiplexer with broadcast: routes one valid/ready input stream
// into four independent single-entry output registers.
module demux_1to4_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       last_sel,
    output logic             last_bcast,
    output logic [7:0]       xfer_cnt,
    output logic             busy
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned CNTW = 8;

    logic [NCH-1:0]   w_dest;
    logic [NCH-1:0]   w_ch_free;
    logic             w_ready;
    logic             w_acc;

    logic [WIDTH-1:0] r_data [NCH];
    logic [NCH-1:0]   r_valid;
    logic [1:0]       r_last_sel;
    logic             r_last_bcast;
    logic [CNTW-1:0]  r_xfer_cnt;

    // A channel draining this cycle counts as free, giving back-to-back loads.
    always_comb begin
        w_dest    = in_bcast ? 4'b1111 : (4'b0001 << in_sel);
        w_ch_free = ~r_valid | out_ready;
        w_ready   = &(w_ch_free | ~w_dest);
        w_acc     = in_valid & w_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_acc && w_dest[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Status of the most recent accepted transfer; a broadcast counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sel   <= '0;
            r_last_bcast <= 1'b0;
            r_xfer_cnt   <= '0;
        end else if (w_acc) begin
            r_last_sel   <= in_sel;
            r_last_bcast <= in_bcast;
            r_xfer_cnt   <= r_xfer_cnt + CNTW'(1);
        end
    end

    assign in_ready   = w_ready;
    assign out_data0  = r_data[0];
    assign out_data1  = r_data[1];
    assign out_data2  = r_data[2];
    assign out_data3  = r_data[3];
    assign out_valid  = r_valid;
    assign last_sel   = r_last_sel;
    assign last_bcast = r_last_bcast;
    assign xfer_cnt   = r_xfer_cnt;
    assign busy       = |r_valid;

endmodule

// File: doc/demux_1to4_8bit.md
Name: demux_1to4_8bit

Overview:
- Distribution-side counterpart of the 4:1 8-bit select mux.
- Routes one 8-bit input stream to one of four output channels, chosen by a 2-bit select, or to all four in broadcast mode.
- Each channel has a 1-entry output register with valid/ready handshake, so the block sits between a single producer and four independent consumers.

Parameters:
- WIDTH, 8, data width of input and each output channel.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input payload
- in_sel  input  2  destination channel index (0..3), ignored when in_bcast=1
- in_bcast  input  1  1 = deliver in_data to all four channels
- in_valid  input  1  producer has data
- in_ready  output  1  block accepts in_data this cycle
- out_data0, out_data1, out_data2, out_data3  output  WIDTH  channel payload registers
- out_valid  output  4  per-channel valid, bit i = channel i
- out_ready  input  4  per-channel consumer ready, bit i = channel i
- last_sel  output  2  in_sel of the most recent accepted transfer
- last_bcast  output  1  in_bcast of the most recent accepted transfer
- xfer_cnt  output  8  count of accepted input transfers
- busy  output  1  OR of out_valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=4'b0000, all out_dataN=0, last_sel=0, last_bcast=0, xfer_cnt=0.
  - Pending channel data is discarded immediately, mid-transfer included.
  - in_ready=1 while in reset is don't-care; the bench must not send during reset.
- Destination decode (combinational): dest = 4'b1111 if in_bcast, else one-hot of in_sel (00->0001, 01->0010, 10->0100, 11->1000).
- Channel free: ch_free[i] = ~out_valid[i] | out_ready[i]. A full channel is free in the same cycle it drains.
- Ready: in_ready = AND over i of (ch_free[i] | ~dest[i]).
  - Broadcast requires all four channels free.
  - in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. This path is intentional.
- Accept: acc = in_valid & in_ready. in_data and in_sel must be held stable by the producer while in_valid=1 and in_ready=0.
- Per channel i, each rising edge, in priority order:
  - If acc & dest[i]: out_dataN <= in_data, out_valid[i] <= 1. This covers load while the old word drains (back-to-back, no bubble).
  - Else if out_ready[i]: out_valid[i] <= 0, out_dataN holds.
  - Else: hold.
- Latency: accepted word is visible on out_dataN/out_valid the cycle after acc. Throughput is 1 word/cycle per channel when the consumer keeps ready=1.
- out_dataN must not change while out_valid[i]=1 and out_ready[i]=0.
- On acc:
  - last_sel <= in_sel, last_bcast <= in_bcast.
  - xfer_cnt <= xfer_cnt+1, wrapping 255->0. A broadcast counts as 1.
- busy is combinational: |out_valid.
- Blocking: a stalled channel blocks only transfers addressed to it and broadcasts. Transfers to other channels proceed.
- out_ready[i]=1 with out_valid[i]=0 has no effect.

Test Plan:
- Reset, then in_sel=2, in_data=0xA5, in_valid=1 for 1 cycle, out_ready=4'b0000 -> next cycle out_valid=4'b0100, out_data2=0xA5, xfer_cnt=1, last_sel=2, busy=1; channel 2 holds 0xA5 while stalled.
- Channel 1 full and stalled (out_ready[1]=0), send to ch1 -> in_ready=0, no change. Send to ch3 -> accepted, out_data3 updated. Raise out_ready[1] -> in_ready=1 the same cycle; new word 0x3C loads ch1 next cycle with out_valid[1] staying 1.
- Broadcast 0x5A with ch0 full/stalled -> in_ready=0. Release ch0 -> next cycle out_valid=4'b1111, all out_dataN=0x5A, last_bcast=1, xfer_cnt incremented by 1.
- Streaming 300 words round-robin over sel 0..3 with out_ready=4'b1111 -> in_ready constantly 1, each channel receives its words in order with 1-cycle latency, xfer_cnt ends at 300 mod 256 = 44.
- Assert rst_n=0 asynchronously mid-stream with out_valid=4'b1011 -> outputs clear before the next clock edge: out_valid=0, xfer_cnt=0, busy=0. After release, first transfer behaves as from power-up.
- Random in_valid/out_ready/in_sel/in_bcast for 10k cycles against a scoreboard -> no drops, no duplicates, per-channel order preserved, data stable under stall.
